// File: rtl/supernova_mdu_rs.sv
// Reservation station for the Supernova MDU: compacting age-ordered queue with
// CDB operand capture and oldest-ready select over a valid/ready issue port.

module supernova_mdu_rs_wake #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 7
) (
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [XLEN-1:0]  cdb_data_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             rdy_i,
    input  logic [XLEN-1:0]  data_i,
    output logic             rdy_o,
    output logic [XLEN-1:0]  data_o
);
    logic hit;

    assign hit    = cdb_valid_i & ~rdy_i & (tag_i == cdb_tag_i);
    assign rdy_o  = rdy_i | hit;
    assign data_o = hit ? cdb_data_i : data_i;
endmodule

module supernova_mdu_rs #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int TAG_W = 7,
    parameter int ROB_W = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_in,
    input  logic                       disp_valid_in,
    output logic                       disp_ready_out,
    input  logic [31:0]                disp_instr_in,
    input  logic [TAG_W-1:0]           disp_rd_tag_in,
    input  logic [ROB_W-1:0]           disp_rob_idx_in,
    input  logic [TAG_W-1:0]           disp_src1_tag_in,
    input  logic                       disp_src1_ready_in,
    input  logic [XLEN-1:0]            disp_src1_data_in,
    input  logic [TAG_W-1:0]           disp_src2_tag_in,
    input  logic                       disp_src2_ready_in,
    input  logic [XLEN-1:0]            disp_src2_data_in,
    input  logic                       cdb_valid_in,
    input  logic [TAG_W-1:0]           cdb_tag_in,
    input  logic [XLEN-1:0]            cdb_data_in,
    output logic                       iss_valid_out,
    input  logic                       iss_ready_in,
    output logic [31:0]                iss_instr_out,
    output logic [XLEN-1:0]            iss_src1_data_out,
    output logic [XLEN-1:0]            iss_src2_data_out,
    output logic [TAG_W-1:0]           iss_rd_tag_out,
    output logic [ROB_W-1:0]           iss_rob_idx_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             rdy;
        logic [XLEN-1:0]  data;
    } src_t;

    typedef struct packed {
        logic [31:0]      instr;
        logic [TAG_W-1:0] rd_tag;
        logic [ROB_W-1:0] rob_idx;
        src_t             s1;
        src_t             s2;
    } ent_t;

    ent_t slot_q [DEPTH];
    ent_t slot_d [DEPTH];
    ent_t woke   [DEPTH];
    ent_t disp_ent;

    logic [CNT_W-1:0]           count_q, count_d, wr_idx;
    logic [DEPTH-1:0]           occ;
    logic [DEPTH-1:0]           w1_rdy, w2_rdy;
    logic [DEPTH-1:0][XLEN-1:0] w1_data, w2_data;
    logic                       b1_rdy, b2_rdy;
    logic [XLEN-1:0]            b1_data, b2_data;
    logic                       sel_found;
    logic [IDX_W-1:0]           sel_idx;
    logic                       iss_fire, disp_fire;

    // Every slot sees the CDB each cycle; shifted slots carry the woken copy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign occ[g] = count_q > CNT_W'(g);

        supernova_mdu_rs_wake #(.XLEN(XLEN), .TAG_W(TAG_W)) u_w1 (
            .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
            .tag_i(slot_q[g].s1.tag), .rdy_i(slot_q[g].s1.rdy), .data_i(slot_q[g].s1.data),
            .rdy_o(w1_rdy[g]), .data_o(w1_data[g])
        );
        supernova_mdu_rs_wake #(.XLEN(XLEN), .TAG_W(TAG_W)) u_w2 (
            .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
            .tag_i(slot_q[g].s2.tag), .rdy_i(slot_q[g].s2.rdy), .data_i(slot_q[g].s2.data),
            .rdy_o(w2_rdy[g]), .data_o(w2_data[g])
        );
    end

    supernova_mdu_rs_wake #(.XLEN(XLEN), .TAG_W(TAG_W)) u_byp1 (
        .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
        .tag_i(disp_src1_tag_in), .rdy_i(disp_src1_ready_in), .data_i(disp_src1_data_in),
        .rdy_o(b1_rdy), .data_o(b1_data)
    );
    supernova_mdu_rs_wake #(.XLEN(XLEN), .TAG_W(TAG_W)) u_byp2 (
        .cdb_valid_i(cdb_valid_in), .cdb_tag_i(cdb_tag_in), .cdb_data_i(cdb_data_in),
        .tag_i(disp_src2_tag_in), .rdy_i(disp_src2_ready_in), .data_i(disp_src2_data_in),
        .rdy_o(b2_rdy), .data_o(b2_data)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke[i]         = slot_q[i];
            woke[i].s1.rdy  = w1_rdy[i];
            woke[i].s1.data = w1_data[i];
            woke[i].s2.rdy  = w2_rdy[i];
            woke[i].s2.data = w2_data[i];
        end
    end

    always_comb begin
        disp_ent         = '0;
        disp_ent.instr   = disp_instr_in;
        disp_ent.rd_tag  = disp_rd_tag_in;
        disp_ent.rob_idx = disp_rob_idx_in;
        disp_ent.s1.tag  = disp_src1_tag_in;
        disp_ent.s1.rdy  = b1_rdy;
        disp_ent.s1.data = b1_data;
        disp_ent.s2.tag  = disp_src2_tag_in;
        disp_ent.s2.rdy  = b2_rdy;
        disp_ent.s2.data = b2_data;
    end

    // Select uses registered readiness, so a wakeup becomes eligible next cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && occ[i] && slot_q[i].s1.rdy && slot_q[i].s2.rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign disp_ready_out    = count_q < CNT_W'(DEPTH);
    assign iss_valid_out     = sel_found & ~flush_in;
    assign iss_fire          = iss_valid_out & iss_ready_in;
    assign disp_fire         = disp_valid_in & disp_ready_out & ~flush_in;
    assign wr_idx            = count_q - CNT_W'(iss_fire);
    assign count_out         = count_q;

    assign iss_instr_out     = sel_found ? slot_q[sel_idx].instr   : '0;
    assign iss_src1_data_out = sel_found ? slot_q[sel_idx].s1.data : '0;
    assign iss_src2_data_out = sel_found ? slot_q[sel_idx].s2.data : '0;
    assign iss_rd_tag_out    = sel_found ? slot_q[sel_idx].rd_tag  : '0;
    assign iss_rob_idx_out   = sel_found ? slot_q[sel_idx].rob_idx : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = woke[i];
        end
        if (iss_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) slot_d[i] = woke[i+1];
            end
        end
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) slot_d[i] = disp_ent;
            end
        end

        count_d = count_q;
        if (flush_in)                   count_d = '0;
        else if (iss_fire && !disp_fire) count_d = count_q - CNT_W'(1);
        else if (disp_fire && !iss_fire) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
        end
    end
endmodule

// File: tb/tb_supernova_mdu_rs.sv
// Bench for supernova_mdu_rs: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the station.

module tb_supernova_mdu_rs;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int TAG_W = 7;
    localparam int ROB_W = 6;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush_in = 1'b0;
    logic             disp_valid_in = 1'b0;
    logic             disp_ready_out;
    logic [31:0]      disp_instr_in = '0;
    logic [TAG_W-1:0] disp_rd_tag_in = '0;
    logic [ROB_W-1:0] disp_rob_idx_in = '0;
    logic [TAG_W-1:0] disp_src1_tag_in = '0, disp_src2_tag_in = '0;
    logic             disp_src1_ready_in = 1'b0, disp_src2_ready_in = 1'b0;
    logic [XLEN-1:0]  disp_src1_data_in = '0, disp_src2_data_in = '0;
    logic             cdb_valid_in = 1'b0;
    logic [TAG_W-1:0] cdb_tag_in = '0;
    logic [XLEN-1:0]  cdb_data_in = '0;
    logic             iss_valid_out;
    logic             iss_ready_in = 1'b0;
    logic [31:0]      iss_instr_out;
    logic [XLEN-1:0]  iss_src1_data_out, iss_src2_data_out;
    logic [TAG_W-1:0] iss_rd_tag_out;
    logic [ROB_W-1:0] iss_rob_idx_out;
    logic [CW-1:0]    count_out;

    always #5 clk = ~clk;

    supernova_mdu_rs #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in),
        .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
        .disp_instr_in(disp_instr_in), .disp_rd_tag_in(disp_rd_tag_in),
        .disp_rob_idx_in(disp_rob_idx_in),
        .disp_src1_tag_in(disp_src1_tag_in), .disp_src1_ready_in(disp_src1_ready_in),
        .disp_src1_data_in(disp_src1_data_in),
        .disp_src2_tag_in(disp_src2_tag_in), .disp_src2_ready_in(disp_src2_ready_in),
        .disp_src2_data_in(disp_src2_data_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
        .iss_valid_out(iss_valid_out), .iss_ready_in(iss_ready_in),
        .iss_instr_out(iss_instr_out), .iss_src1_data_out(iss_src1_data_out),
        .iss_src2_data_out(iss_src2_data_out), .iss_rd_tag_out(iss_rd_tag_out),
        .iss_rob_idx_out(iss_rob_idx_out), .count_out(count_out)
    );

    typedef struct {
        logic [31:0]      instr;
        logic [TAG_W-1:0] rd;
        logic [ROB_W-1:0] rob;
        logic [TAG_W-1:0] t1, t2;
        logic             r1, r2;
        logic [XLEN-1:0]  d1, d2;
    } ment_t;

    ment_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_sel();
        for (int i = 0; i < q.size(); i++)
            if (q[i].r1 && q[i].r2) return i;
        return -1;
    endfunction

    task automatic check_outputs();
        int s;
        s = model_sel();
        chk("count", 64'(count_out), 64'(q.size()));
        chk("disp_ready", 64'(disp_ready_out), 64'(q.size() < DEPTH));
        chk("iss_valid", 64'(iss_valid_out), 64'(s >= 0 && !flush_in));
        if (s >= 0) begin
            chk("instr", 64'(iss_instr_out), 64'(q[s].instr));
            chk("src1", iss_src1_data_out, q[s].d1);
            chk("src2", iss_src2_data_out, q[s].d2);
            chk("rd_tag", 64'(iss_rd_tag_out), 64'(q[s].rd));
            chk("rob_idx", 64'(iss_rob_idx_out), 64'(q[s].rob));
        end else begin
            chk("idle_payload", 64'(iss_instr_out) | iss_src1_data_out | iss_src2_data_out
                | 64'(iss_rd_tag_out) | 64'(iss_rob_idx_out), 64'd0);
        end
    endtask

    task automatic model_step();
        int    s;
        ment_t e;
        s = model_sel();
        if (flush_in) begin
            q.delete();
            return;
        end
        if (s >= 0 && iss_ready_in) q.delete(s);
        if (disp_valid_in && count_out < CW'(DEPTH) && q.size() < DEPTH) begin
            e.instr = disp_instr_in; e.rd = disp_rd_tag_in; e.rob = disp_rob_idx_in;
            e.t1 = disp_src1_tag_in; e.r1 = disp_src1_ready_in; e.d1 = disp_src1_data_in;
            e.t2 = disp_src2_tag_in; e.r2 = disp_src2_ready_in; e.d2 = disp_src2_data_in;
            q.push_back(e);
        end
        // A broadcast wakes every waiting source, including one entering this cycle.
        if (cdb_valid_in) begin
            foreach (q[i]) begin
                if (!q[i].r1 && q[i].t1 == cdb_tag_in) begin q[i].r1 = 1'b1; q[i].d1 = cdb_data_in; end
                if (!q[i].r2 && q[i].t2 == cdb_tag_in) begin q[i].r2 = 1'b1; q[i].d2 = cdb_data_in; end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic edge_step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        edge_step();
    endtask

    task automatic idle();
        disp_valid_in = 1'b0;
        cdb_valid_in  = 1'b0;
        flush_in      = 1'b0;
    endtask

    task automatic disp(input logic [31:0] ins, input int rd, input int rob,
                        input int t1, input int r1, input logic [63:0] d1,
                        input int t2, input int r2, input logic [63:0] d2);
        disp_valid_in      = 1'b1;
        disp_instr_in      = ins;
        disp_rd_tag_in     = TAG_W'(rd);
        disp_rob_idx_in    = ROB_W'(rob);
        disp_src1_tag_in   = TAG_W'(t1);
        disp_src1_ready_in = (r1 != 0);
        disp_src1_data_in  = d1;
        disp_src2_tag_in   = TAG_W'(t2);
        disp_src2_ready_in = (r2 != 0);
        disp_src2_data_in  = d2;
    endtask

    task automatic cdb(input int tag, input logic [63:0] data);
        cdb_valid_in = 1'b1;
        cdb_tag_in   = TAG_W'(tag);
        cdb_data_in  = data;
    endtask

    initial begin
        // Reset state
        #2;
        check_outputs();
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ready-ready dispatch issues the next cycle and drains
        iss_ready_in = 1'b1;
        disp(32'h02c58533, 5, 3, 1, 1, 64'd7, 2, 1, 64'd6);
        tick();
        idle();
        settle();
        chk("rr_valid", 64'(iss_valid_out), 64'd1);
        chk("rr_src1", iss_src1_data_out, 64'd7);
        chk("rr_src2", iss_src2_data_out, 64'd6);
        chk("rr_rd", 64'(iss_rd_tag_out), 64'd5);
        chk("rr_rob", 64'(iss_rob_idx_out), 64'd3);
        edge_step();
        settle();
        chk("rr_count", 64'(count_out), 64'd0);
        edge_step();

        // Wakeup: wrong tag ignored, matching tag makes it eligible one cycle later
        disp(32'h02c5c533, 8, 4, 1, 1, 64'd3, 12, 0, 64'd0);
        tick();
        idle();
        cdb(11, 64'h99);
        tick();
        idle();
        cdb(12, 64'h10);
        settle();
        chk("wk_pre", 64'(iss_valid_out), 64'd0);
        edge_step();
        idle();
        settle();
        chk("wk_valid", 64'(iss_valid_out), 64'd1);
        chk("wk_src2", iss_src2_data_out, 64'h10);
        edge_step();

        // Oldest-first with compaction
        iss_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(32'h02000033 + 32'(i), 10 + i, 10 + i, 1, 1, 64'(100 + i), 2, 1, 64'(200 + i));
            tick();
        end
        disp(32'h0200003e, 14, 14, 1, 1, 64'd104, 2, 1, 64'd204);
        settle();
        chk("of_full", 64'(disp_ready_out), 64'd0);
        chk("of_a", 64'(iss_rob_idx_out), 64'd10);
        iss_ready_in = 1'b1;
        edge_step();
        iss_ready_in = 1'b0;
        idle();
        settle();
        chk("of_b", 64'(iss_rob_idx_out), 64'd11);
        chk("of_cnt3", 64'(count_out), 64'd3);
        edge_step();
        iss_ready_in = 1'b1;
        disp(32'h0200003e, 14, 14, 1, 1, 64'd104, 2, 1, 64'd204);
        tick();
        idle();
        iss_ready_in = 1'b0;
        settle();
        chk("of_keep3", 64'(count_out), 64'd3);
        edge_step();
        iss_ready_in = 1'b1;
        repeat (4) tick();

        // Out-of-order readiness
        disp(32'h02100033, 21, 21, 20, 0, 64'd0, 2, 1, 64'd9);
        tick();
        disp(32'h02100034, 22, 22, 1, 1, 64'd8, 2, 1, 64'd9);
        tick();
        idle();
        settle();
        chk("ooo_b", 64'(iss_rob_idx_out), 64'd22);
        edge_step();
        cdb(20, 64'h55);
        settle();
        chk("ooo_wait", 64'(iss_valid_out), 64'd0);
        edge_step();
        idle();
        settle();
        chk("ooo_a", 64'(iss_rob_idx_out), 64'd21);
        chk("ooo_a_src1", iss_src1_data_out, 64'h55);
        edge_step();

        // MDU busy backpressure
        iss_ready_in = 1'b0;
        disp(32'h02200033, 40, 40, 1, 1, 64'hAAAA, 2, 1, 64'hBBBB);
        tick();
        disp(32'h02200034, 41, 41, 1, 1, 64'hCCCC, 2, 1, 64'hDDDD);
        tick();
        idle();
        for (int i = 0; i < 35; i++) begin
            settle();
            chk("bp_valid", 64'(iss_valid_out), 64'd1);
            chk("bp_rob", 64'(iss_rob_idx_out), 64'd40);
            chk("bp_src1", iss_src1_data_out, 64'hAAAA);
            edge_step();
        end
        iss_ready_in = 1'b1;
        repeat (3) tick();

        // Flush with a same-cycle dispatch and issue
        iss_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(32'h02300033, 50 + i, 50 + i, 1, 1, 64'(i), 2, 1, 64'(i));
            tick();
        end
        disp(32'h02300036, 53, 53, 1, 1, 64'd3, 2, 1, 64'd3);
        flush_in = 1'b1;
        iss_ready_in = 1'b1;
        settle();
        chk("fl_noiss", 64'(iss_valid_out), 64'd0);
        edge_step();
        idle();
        settle();
        chk("fl_cnt", 64'(count_out), 64'd0);
        edge_step();

        // Asynchronous reset mid-fill
        iss_ready_in = 1'b0;
        disp(32'h02400033, 60, 60, 1, 1, 64'd1, 2, 1, 64'd2);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cnt", 64'(count_out), 64'd0);
        chk("rst_rdy", 64'(disp_ready_out), 64'd1);
        chk("rst_valid", 64'(iss_valid_out), 64'd0);
        chk("rst_payload", 64'(iss_instr_out) | iss_src1_data_out | 64'(iss_rob_idx_out), 64'd0);
        q.delete();
        idle();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(0, 2) != 0)
                disp($urandom, $urandom_range(0, 127), $urandom_range(0, 63),
                     $urandom_range(0, 15), $urandom_range(0, 1), {$urandom, $urandom},
                     $urandom_range(0, 15), $urandom_range(0, 1), {$urandom, $urandom});
            if ($urandom_range(0, 1) != 0) cdb($urandom_range(0, 15), {$urandom, $urandom});
            iss_ready_in = ($urandom_range(0, 3) != 0);
            flush_in = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/supernova_mdu_rs.md
# supernova_mdu_rs

Reservation station for the Supernova 'M' (multiply/divide) unit. Sits between rename/dispatch and `supernova_mdu_unit`. It buffers up to DEPTH MDU micro-ops and captures missing source operands from the common data bus (CDB). It issues the oldest operand-complete entry over a valid/ready handshake to the MDU, whose `req_ready_out` drops while it is busy.

## Interface
- DEPTH, 4: number of entries (≥2).
- XLEN, 64: operand width.
- TAG_W, 7: physical GPR tag width (equals supernova_pkg::GPR_TAG_WIDTH).
- ROB_W, 6: ROB index width (equals supernova_pkg::ROB_IDX_WIDTH).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_in  in  1  synchronous squash of all entries.
- disp_valid_in  in  1  dispatch request.
- disp_ready_out  out  1  space available.
- disp_instr_in  in  32  raw instruction word.
- disp_rd_tag_in  in  TAG_W  destination physical tag.
- disp_rob_idx_in  in  ROB_W  ROB index.
- disp_srcN_tag_in / disp_srcN_ready_in / disp_srcN_data_in  in  TAG_W / 1 / XLEN  source N∈{1,2}: producer tag, value-valid flag, value.
- cdb_valid_in, cdb_tag_in, cdb_data_in  in  1 / TAG_W / XLEN  result broadcast.
- iss_valid_out  out  1  an entry is offered to the MDU.
- iss_ready_in  in  1  MDU accepts (MDU `req_ready_out`).
- iss_instr_out, iss_src1_data_out, iss_src2_data_out, iss_rd_tag_out, iss_rob_idx_out  out  32/XLEN/XLEN/TAG_W/ROB_W  payload of offered entry.
- count_out  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage: compacting ordered queue. Slot 0 is oldest; occupied slots are contiguous 0..count-1.
- Each slot holds instr, rd_tag, rob_idx, and per-source {tag, rdy, data}.
- Wakeup: when cdb_valid_in=1, every occupied slot with srcN.rdy=0 and srcN.tag==cdb_tag_in sets rdy=1 and data=cdb_data_in.
- Dispatch bypass: if a source enters with disp_srcN_ready_in=0 and its tag matches a same-cycle valid CDB, it is stored ready with the CDB data.
- Select: lowest-index occupied slot with src1.rdy & src2.rdy. iss_valid_out=1 iff such a slot exists and flush_in=0. Payload is driven combinationally from that slot (zeros when none).
- Issue fires on iss_valid_out & iss_ready_in. The selected slot is removed; slots above it shift down by one, and their CDB wakeup is applied during the shift.
- Dispatch fires on disp_valid_in & disp_ready_out. The write goes to index count (or count-1 if an issue fires the same cycle).
- disp_ready_out = (count < DEPTH), from registered count only. A full station does not accept dispatch even if an issue frees a slot that cycle.
- Dispatch and issue in the same cycle: both take effect; count is unchanged.
- flush_in=1: all slots are invalidated and count=0 next cycle. The same-cycle dispatch and issue are discarded, and iss_valid_out is forced 0.
- No decoding of instr. Non-M instructions pass through; the MDU traps them.

## Timing
- Reset values: count_out=0, disp_ready_out=1, iss_valid_out=0, all payload outputs 0, all slots invalid.
- Dispatch→issue: an entry dispatched with both sources ready (or bypassed from CDB) can be offered in the cycle after the dispatch edge (1-cycle minimum).
- Wakeup→issue: a CDB broadcast in cycle N makes the entry eligible in cycle N+1.
- Issue→MDU: the MDU samples the payload in the cycle iss_valid_out & iss_ready_in. The payload must stay stable while iss_valid_out=1 and iss_ready_in=0, unless an older slot becomes ready or a flush occurs.
- Reset asserted mid-operation clears everything asynchronously. Outputs take their reset values immediately.

## Test plan
- Ready-ready dispatch: DEPTH=4, dispatch MUL, src1=7, src2=6, both ready, rd_tag=5, rob_idx=3, iss_ready_in=1 → next cycle iss_valid_out=1 with payload {7,6,5,3}; following cycle count_out=0.
- Wakeup: dispatch with src2 tag 12 not ready; CDB tag 12 data 0x10 two cycles later → iss_valid_out rises exactly one cycle after the CDB cycle, iss_src2_data_out=0x10. A CDB with tag 11 has no effect.
- Oldest-first with compaction: fill 4 entries A–D, all ready, iss_ready_in=0 → disp_ready_out=0 and A is offered. Pulse iss_ready_in for 1 cycle → B is offered next and count_out=3. Simultaneously dispatch E → count_out stays 3.
- Out-of-order readiness: A waits on tag 20 and B is ready → B issues first. A issues after CDB tag 20.
- MDU busy backpressure: iss_ready_in=0 for 35 cycles while ready → payload is stable throughout and no entry is lost.
- Flush and reset: flush with 3 entries plus a same-cycle dispatch → count_out=0 next cycle and no issue fires. Assert rst_n low mid-fill → outputs go to reset values immediately.
